// File: rtl/weight_loader.sv
// Weight-stream write sequencer: turns accepted ready/valid beats into one-hot,
// single-cycle writes across the per-neuron weight memories of a layer.

module weight_loader_lane #(
  parameter int neuronWidth = 5,
  parameter int laneIdx     = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   accept,
  input  logic [neuronWidth-1:0] cur_neuron,
  output logic                   wen
);
  always_ff @(posedge clk) begin
    if (!rst_n) wen <= 1'b0;
    else        wen <= accept && (cur_neuron == neuronWidth'(laneIdx));
  end
endmodule

module weight_loader #(
  parameter int numNeurons   = 30,
  parameter int numWeight    = 784,
  parameter int addressWidth = 10,
  parameter int dataWidth    = 16,
  parameter int neuronWidth  = 5
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cfg_start,
  input  logic [neuronWidth-1:0]  cfg_neuron,
  input  logic [neuronWidth-1:0]  cfg_count,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [dataWidth-1:0]    s_data,
  input  logic                    s_last,
  output logic [numNeurons-1:0]   wen,
  output logic [addressWidth-1:0] wadd,
  output logic [dataWidth-1:0]    win,
  output logic                    busy,
  output logic                    done,
  output logic                    err
);
  typedef enum logic [1:0] {IDLE, LOAD, FLUSH} state_t;

  localparam logic [addressWidth-1:0] LAST_ADDR = addressWidth'(numWeight - 1);
  localparam logic [neuronWidth:0]    NN        = (neuronWidth + 1)'(numNeurons);

  state_t                  state, state_nxt;
  logic [neuronWidth-1:0]  cur_neuron, remaining;
  logic [addressWidth-1:0] addr;
  logic [neuronWidth:0]    cfg_end;
  logic                    cfg_zero, cfg_bad, cfg_ok;
  logic                    accept, last_word, final_beat;

  // Config is only honoured in IDLE; a zero count short-circuits the range check.
  assign cfg_end    = {1'b0, cfg_neuron} + {1'b0, cfg_count};
  assign cfg_zero   = cfg_start && (state == IDLE) && (cfg_count == '0);
  assign cfg_bad    = cfg_start && (state == IDLE) && (cfg_count != '0) && (cfg_end > NN);
  assign cfg_ok     = cfg_start && (state == IDLE) && (cfg_count != '0) && !(cfg_end > NN);
  assign accept     = (state == LOAD) && s_valid;
  assign last_word  = (addr == LAST_ADDR);
  assign final_beat = accept && last_word && (remaining == neuronWidth'(1));

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (cfg_zero)    state_nxt = FLUSH;
        else if (cfg_ok) state_nxt = LOAD;
      end
      LOAD:    if (accept && (final_beat || s_last)) state_nxt = FLUSH;
      FLUSH:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    s_ready = (state == LOAD);
    busy    = (state != IDLE);
  end

  // done is registered so it lands one cycle after the final wen cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cur_neuron <= '0;
      remaining  <= '0;
      addr       <= '0;
      wadd       <= '0;
      win        <= '0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      done <= (state == FLUSH) || cfg_bad;
      if (cfg_bad)                      err <= 1'b1;
      else if (cfg_ok || cfg_zero)      err <= 1'b0;
      else if (accept && (s_last != final_beat)) err <= 1'b1;
      if (cfg_ok) begin
        cur_neuron <= cfg_neuron;
        remaining  <= cfg_count;
        addr       <= '0;
      end
      if (accept) begin
        wadd <= addr;
        win  <= s_data;
        if (last_word) begin
          addr       <= '0;
          cur_neuron <= cur_neuron + neuronWidth'(1);
          remaining  <= remaining - neuronWidth'(1);
        end else begin
          addr <= addr + addressWidth'(1);
        end
      end
    end
  end

  for (genvar i = 0; i < numNeurons; i++) begin : g_lane
    weight_loader_lane #(
      .neuronWidth (neuronWidth),
      .laneIdx     (i)
    ) u_lane (
      .clk        (clk),
      .rst_n      (rst_n),
      .accept     (accept),
      .cur_neuron (cur_neuron),
      .wen        (wen[i])
    );
  end
endmodule
